// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, op-code encoding and the legality check.
package alu_pkg;

    localparam int XLEN       = 32;
    localparam int ALU_OP_W   = 4;
    localparam int ALU_OP_MAX = 6;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6
    } alu_op_e;

    function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
        return op <= ALU_OP_W'(ALU_OP_MAX);
    endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Requester and response channels of the shared-ALU arbiter.
// With ALU_SHARE_ARB_ERR_EN defined the response also carries rsp_err.
interface alu_share_arb_if
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) ();

    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*XLEN-1:0]     req_a;
    logic [NREQ*XLEN-1:0]     req_b;
    logic [NREQ*ALU_OP_W-1:0] req_op;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [XLEN-1:0]          rsp_result;
    logic [IDW-1:0]           rsp_id;
`ifdef ALU_SHARE_ARB_ERR_EN
    logic                     rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_id, rsp_err
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_id, rsp_err
    );
`else
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_id
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_id
    );
`endif

endinterface

// File: rtl/alu_share_arb_alu.sv
// Purely combinational 32-bit ALU; unassigned op codes produce zero.
module alu
    import alu_pkg::*;
(
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    input  logic [ALU_OP_W-1:0] op,
    output logic [XLEN-1:0]     y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLL: y = a << b[4:0];
            ALU_SRL: y = a >> b[4:0];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb_rr_grant.sv
// Round-robin grant: first set request found scanning from ptr upward, wrapping.
module rr_grant #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        int          j;
        logic [IDW-1:0] jj;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < NREQ; k++) begin
            j  = (int'(ptr) + k) % NREQ;
            jj = IDW'(j);
            if (!any && req[jj]) begin
                any       = 1'b1;
                grant[jj] = 1'b1;
                idx       = jj;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin time-sharing of one ALU among NREQ requesters with a registered response.
// Optional: ALU_SHARE_ARB_ERR_EN adds rsp_err flagging illegal op codes.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input logic            clk,
    input logic            rst_n,
    alu_share_arb_if.slave bus
);

    logic [NREQ-1:0]     grant;
    logic [IDW-1:0]      gidx;
    logic                gany;
    logic                slot_free;
    logic                accept;
    logic [XLEN-1:0]     mux_a;
    logic [XLEN-1:0]     mux_b;
    logic [ALU_OP_W-1:0] mux_op;
    logic [XLEN-1:0]     alu_y;

    logic                rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]     rsp_result_q, rsp_result_d;
    logic [IDW-1:0]      rsp_id_q, rsp_id_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
`ifdef ALU_SHARE_ARB_ERR_EN
    logic                rsp_err_q, rsp_err_d;
`endif

    rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_rr_grant (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    // The slot is usable when empty or being drained this same cycle.
    assign slot_free     = !rsp_valid_q || bus.rsp_ready;
    assign bus.req_ready = (rst_n && slot_free) ? grant : '0;
    assign accept        = gany && slot_free;

    always_comb begin
        mux_a  = '0;
        mux_b  = '0;
        mux_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == IDW'(i)) begin
                mux_a  = bus.req_a[i*XLEN +: XLEN];
                mux_b  = bus.req_b[i*XLEN +: XLEN];
                mux_op = bus.req_op[i*ALU_OP_W +: ALU_OP_W];
            end
        end
    end

    alu u_alu (
        .a  (mux_a),
        .b  (mux_b),
        .op (mux_op),
        .y  (alu_y)
    );

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        rr_ptr_d     = rr_ptr_q;
`ifdef ALU_SHARE_ARB_ERR_EN
        rsp_err_d    = rsp_err_q;
`endif
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = alu_y;
            rsp_id_d     = gidx;
            rr_ptr_d     = (int'(gidx) == NREQ - 1) ? '0 : gidx + IDW'(1);
`ifdef ALU_SHARE_ARB_ERR_EN
            rsp_err_d    = !alu_op_legal(mux_op);
`endif
        end else if (bus.rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= '0;
            rr_ptr_q     <= '0;
`ifdef ALU_SHARE_ARB_ERR_EN
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            rr_ptr_q     <= rr_ptr_d;
`ifdef ALU_SHARE_ARB_ERR_EN
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_id     = rsp_id_q;
`ifdef ALU_SHARE_ARB_ERR_EN
    assign bus.rsp_err    = rsp_err_q;
`endif

endmodule
